// File: rtl/mdu_if.sv
// mdu_if: pipeline-to-MDU handshake, operands, mthi/mtlo writes and HI/LO results
interface mdu_if #(parameter int WIDTH = 32) ();
  logic             start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, md_op, a, b, hi_we, lo_we, wdata,
                  input busy, done, div_zero, hi, lo);
  modport slave  (input start, md_op, a, b, hi_we, lo_we, wdata,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative shift-add multiplier / restoring divider owning HI/LO.
// Define MDU_DIVZERO_EN to short-circuit div/divu by zero with a div_zero pulse.
module mdu_ctrl #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  mdu_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t             state, nxt;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0]   opb, hi_r, lo_r, a_mag, b_mag, quo, rem;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [CW-1:0]      cnt;
  logic               sa, sb, is_div, dz, done_r, dz_r;
  logic               a_neg, b_neg, ge, last, dz_start;
  assign bus.busy     = state != IDLE;
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  always_comb begin
    a_neg   = bus.md_op[0] & bus.a[WIDTH-1];
    b_neg   = bus.md_op[0] & bus.b[WIDTH-1];
    a_mag   = a_neg ? -bus.a : bus.a;
    b_mag   = b_neg ? -bus.b : bus.b;
`ifdef MDU_DIVZERO_EN
    dz_start = bus.md_op[1] && bus.b == '0;
`else
    dz_start = 1'b0;
`endif
    last    = cnt == CW'(WIDTH - 1);
    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge      = shifted >= {1'b0, opb};
    diff    = shifted - {1'b0, opb};
    prod    = (sa ^ sb) ? -acc : acc;
    quo     = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem     = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    nxt     = state;
    unique case (state)
      IDLE:     nxt = !bus.start ? IDLE : dz_start ? FIX : bus.md_op[1] ? DIV : MUL;
      MUL, DIV: nxt = last ? FIX : state;
      FIX:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      opb    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      cnt    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= {{WIDTH{1'b0}}, a_mag};
            opb    <= b_mag;
            sa     <= a_neg;
            sb     <= b_neg;
            is_div <= bus.md_op[1];
            dz     <= dz_start;
            cnt    <= '0;
          end else begin
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
          end
        end
        MUL: begin
          acc <= {sum, acc[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
        end
        DIV: begin
          acc <= {ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0], acc[WIDTH-2:0], ge};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          done_r <= 1'b1;
          dz_r   <= dz;
          if (!dz) {hi_r, lo_r} <= is_div ? {rem, quo} : prod;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized and directed checks of mdu_ctrl against a 64-bit arithmetic model
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  mdu_if #(32) bus ();
  mdu_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [63:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint q, r, p;
    logic [31:0] qq, rr;
    case (op)
      2'd0: return {32'd0, a} * {32'd0, b};
      2'd1: begin p = sa * sb; return p; end
      2'd2: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) return {a, (sa < 0) ? 32'h1 : 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        qq = q[31:0]; rr = r[31:0];
        return {rr, qq};
      end
    endcase
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
  endtask

  task automatic wait_done(output int cycles, output bit stable);
    logic [31:0] h0, l0;
    int n = 0;
    h0 = bus.hi; l0 = bus.lo; cycles = 0; stable = 1'b1;
    while (bus.done !== 1'b1 && n < 200) begin
      if (bus.busy) cycles++;
      if (bus.hi !== h0 || bus.lo !== l0) stable = 1'b0;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL done_timeout: waited %0d cycles, required done within 200", n); end
  endtask

  task automatic test_reset;
    bus.start = 0; bus.md_op = 0; bus.a = 0; bus.b = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b required 000", {bus.busy, bus.done, bus.div_zero}); end
    checks++;
    if ({bus.hi, bus.lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h required 0", {bus.hi, bus.lo}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int cyc; bit st; logic [63:0] exp;
    exp = model(op, a, b);
    launch(op, a, b);
    wait_done(cyc, st);
    checks++;
    if ({bus.hi, bus.lo} !== exp) begin errors++; $display("FAIL %s: hi:lo got %h required %h (op %0d a %h b %h)", name, {bus.hi, bus.lo}, exp, op, a, b); end
    checks++;
    if (cyc !== 33 || bus.busy !== 1'b0 || !st) begin errors++; $display("FAIL %s_timing: busy cycles %0d busy_at_done %b stable %b required 33 0 1", name, cyc, bus.busy, st); end
  endtask

  task automatic test_directed;
    do_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if ({bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max_const: got %h required fffffffe00000001", {bus.hi, bus.lo}); end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse: done %b one cycle later, required 0", bus.done); end
    do_op("mult_neg", 2'd1, -32'sd3, 32'd5);
    do_op("divu", 2'd2, 32'd100, 32'd7);
    checks++;
    if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_const: got %h required 000000020000000e", {bus.hi, bus.lo}); end
    do_op("div_neg", 2'd3, -32'sd7, 32'd2);
    do_op("div_minneg", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_minneg_const: got %h required 0000000080000000", {bus.hi, bus.lo}); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic [1:0] op; logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 2) == 0) b = $urandom_range(1, 20);
      if ($urandom_range(0, 3) == 0) b = -b;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
      if (b == 0) b = 1;
      do_op("random", op, a, b);
    end
  endtask

  task automatic test_handshake;
    int cyc; bit st;
    launch(2'd0, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.md_op = 2'd2; bus.a = 32'd1; bus.b = 32'd1;
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    wait_done(cyc, st);
    checks++;
    if ({bus.hi, bus.lo} !== 64'd42 || !st) begin errors++; $display("FAIL busy_ignore: got %h stable %b required 000000000000002a 1", {bus.hi, bus.lo}, st); end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL no_queue: busy %b done %b required 0 0", bus.busy, bus.done); end
    bus.lo_we = 1'b1; bus.wdata = 32'hABCD;
    @(negedge clk);
    bus.lo_we = 1'b0;
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0000_0000_0000_ABCD) begin errors++; $display("FAIL mtlo: got %h required 000000000000abcd", {bus.hi, bus.lo}); end
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h77;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0000_0077_0000_0077) begin errors++; $display("FAIL mthi_mtlo: got %h required 0000007700000077", {bus.hi, bus.lo}); end
    bus.start = 1'b1; bus.md_op = 2'd0; bus.a = 32'd3; bus.b = 32'd4;
    bus.hi_we = 1'b1; bus.wdata = 32'h9999;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    wait_done(cyc, st);
    checks++;
    if ({bus.hi, bus.lo} !== 64'd12) begin errors++; $display("FAIL start_wins: got %h required 000000000000000c", {bus.hi, bus.lo}); end
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    launch(2'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (9) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== 64'd0) begin errors++; $display("FAIL reset_mid: busy %b hi:lo %h required 0 0", bus.busy, {bus.hi, bus.lo}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (bus.done || bus.busy) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_abort: done/busy seen %b required 0", seen); end
    do_op("after_reset", 2'd0, 32'd6, 32'd7);
  endtask

  task automatic test_divzero;
    int cyc; bit st;
    logic [63:0] prev;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5A5A;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    prev = {bus.hi, bus.lo};
    launch(2'd2, 32'd5, 32'd0);
    wait_done(cyc, st);
`ifdef MDU_DIVZERO_EN
    checks++;
    if (cyc !== 1 || bus.div_zero !== 1'b1 || {bus.hi, bus.lo} !== prev) begin errors++; $display("FAIL divzero_fast: cycles %0d div_zero %b hi:lo %h required 1 1 %h", cyc, bus.div_zero, {bus.hi, bus.lo}, prev); end
`else
    checks++;
    if (cyc !== 33 || bus.div_zero !== 1'b0 || {bus.hi, bus.lo} !== model(2'd2, 32'd5, 32'd0)) begin errors++; $display("FAIL divzero_base: cycles %0d div_zero %b hi:lo %h required 33 0 %h (prev %h)", cyc, bus.div_zero, {bus.hi, bus.lo}, model(2'd2, 32'd5, 32'd0), prev); end
    do_op("div_zero_signed", 2'd3, -32'sd9, 32'd0);
`endif
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_handshake;
    test_reset_mid;
    test_divzero;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
